// File: rtl/onehot_rr_arbiter.sv
// 16-requester round-robin arbiter with a registered one-hot grant held until acknowledged.
// Optional build macro ONEHOT_ARB_LOCK_EN holds the grant after ack until the granted request drops.
module onehot_rr_arbiter (
  input  logic        clk,
  input  logic        rstN,
  input  logic [15:0] reqIn,
  input  logic        ackIn,
  output logic [15:0] grantOut,
  output logic        grantValid,
  output logic [7:0]  grantCount
);

`ifdef ONEHOT_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_t;
`else
  typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

  state_t      r_state;
  logic [3:0]  r_ptr;
  logic [3:0]  r_idx;
  logic [15:0] r_grant;
  logic        r_valid;
  logic [7:0]  r_count;

  logic [15:0] w_req_excl;
  logic [4:0]  w_pick_idle;
  logic [4:0]  w_pick_next;

  // Returns {found, index} of the first set bit searching base+1, base+2, ... base.
  // NOTE: the loop runs from the farthest offset down so the nearest hit is the last write and wins.
  function automatic logic [4:0] rr_pick(input logic [15:0] req, input logic [3:0] base);
    logic [3:0] idx;
    rr_pick = 5'b0;
    for (int k = 16; k >= 1; k--) begin
      idx = base + 4'(k);
      if (req[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  assign w_req_excl  = reqIn & ~r_grant;
  assign w_pick_idle = rr_pick(reqIn, r_ptr);
  // After an ack the pointer becomes the granted index, so search from r_idx directly.
  assign w_pick_next = rr_pick(w_req_excl, r_idx);

  assign grantOut   = r_grant;
  assign grantValid = r_valid;
  assign grantCount = r_count;

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= IDLE;
      r_ptr   <= 4'hF;
      r_idx   <= 4'h0;
      r_grant <= 16'h0000;
      r_valid <= 1'b0;
      r_count <= 8'h00;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pick_idle[4]) begin
            r_idx   <= w_pick_idle[3:0];
            r_grant <= 16'h0001 << w_pick_idle[3:0];
            r_valid <= 1'b1;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (ackIn) begin
            r_ptr   <= r_idx;
            r_count <= r_count + 8'd1;
`ifdef ONEHOT_ARB_LOCK_EN
            r_state <= LOCK;
`else
            if (w_pick_next[4]) begin
              r_idx   <= w_pick_next[3:0];
              r_grant <= 16'h0001 << w_pick_next[3:0];
            end else begin
              r_grant <= 16'h0000;
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
`endif
          end
        end
`ifdef ONEHOT_ARB_LOCK_EN
        LOCK: begin
          if (ackIn) r_count <= r_count + 8'd1;
          if (!reqIn[r_idx]) begin
            if (w_pick_next[4]) begin
              r_idx   <= w_pick_next[3:0];
              r_grant <= 16'h0001 << w_pick_next[3:0];
              r_state <= GRANT;
            end else begin
              r_grant <= 16'h0000;
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/onehot_rr_arbiter.md
ONEHOT_RR_ARBITER -- requirements
Module: onehot_rr_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rstN  input  1  asynchronous active-low reset.
REQ-004 reqIn  input  16  request lines, bit i = requester i, level-sensitive.
REQ-005 ackIn  input  1  downstream (16-to-4 encoder stage) has consumed the current grant.
REQ-006 grantOut  output  16  registered one-hot grant, all-zero when no grant; feeds the encoder data input.
REQ-007 grantValid  output  1  registered; high exactly when grantOut is non-zero; feeds the encoder enable.
REQ-008 grantCount  output  8  registered count of acknowledged grants.

Function
REQ-009 States: IDLE, GRANT, LOCK (LOCK present only per REQ-021); state, pointer, grantOut, grantValid and grantCount SHALL be registered.
REQ-010 Round-robin pointer ptr (4 bits) SHALL hold the index of the last acknowledged requester; search order SHALL be ptr+1, ptr+2, ... wrapping 15 to 0, ending at ptr itself.
REQ-011 IDLE: if reqIn is non-zero at a clock edge, the block SHALL load grantOut with the one-hot of the first set bit in search order, set grantValid, and enter GRANT; else stay IDLE with grantOut = 0.
REQ-012 Latency from a request asserted in IDLE to grantValid high SHALL be one clock.
REQ-013 GRANT: grantOut and grantValid SHALL be held stable until ackIn is sampled high, regardless of changes to reqIn, including withdrawal of the granted request.
REQ-014 On ackIn high in GRANT: ptr SHALL be loaded with the granted index, grantCount incremented by 1 (modulo 256, 255 wraps to 0).
REQ-015 On ack in GRANT (no lock): if reqIn, excluding the just-granted bit, is non-zero, the next grant SHALL be issued on the following edge with no idle cycle, using the updated ptr; otherwise the state SHALL return to IDLE with grantOut = 0.
REQ-016 The just-granted requester SHALL be re-granted back-to-back only if it is the sole active request, and then only after one IDLE cycle.
REQ-017 ackIn while grantValid is low SHALL be ignored, with no change to ptr or grantCount.
REQ-018 grantOut SHALL never have more than one bit set.

Reset
REQ-019 While rstN is low: state = IDLE, grantOut = 16'h0000, grantValid = 0, grantCount = 8'h00, ptr = 4'hF (so bit 0 has first priority).
REQ-020 Reset assertion mid-grant SHALL clear all outputs immediately (asynchronously); after release the first arbitration SHALL occur on the first rising edge with rstN high.

Configuration
REQ-021 Macro ONEHOT_ARB_LOCK_EN: when defined, an ack in GRANT SHALL move to LOCK, holding the same grantOut/grantValid until the granted reqIn bit is sampled low, then re-arbitrate as in REQ-015; further ackIn in LOCK SHALL increment grantCount without changing ptr.
REQ-022 When ONEHOT_ARB_LOCK_EN is undefined, LOCK SHALL not exist and behaviour SHALL be exactly REQ-011 to REQ-017.

Verification
REQ-023 Reset, then reqIn = 16'h0001 -> one clock later grantOut = 16'h0001, grantValid = 1; ack -> grantCount = 1, state IDLE.
REQ-024 reqIn = 16'hFFFF, ackIn held high -> grants cycle 0001, 0002, 0004 ... 8000, 0001 on consecutive clocks; grantCount reaches 16 after 16 acks.
REQ-025 After ptr = 5, reqIn = 16'h0021 (bits 0 and 5) -> grantOut = 16'h0001 (bit 0 wins over re-grant of 5).
REQ-026 Grant 16'h0004 pending, reqIn dropped to 0 without ack -> grantOut stays 16'h0004 until ack, then IDLE.
REQ-027 Assert rstN = 0 mid-GRANT with grantOut = 16'h0100 -> grantOut = 0, grantValid = 0, grantCount = 0 before next edge; release with reqIn = 16'h0300 -> grantOut = 16'h0100.
REQ-028 With ONEHOT_ARB_LOCK_EN: grant 16'h0008, ack, reqIn[3] held 3 more clocks -> grantOut stays 16'h0008 until reqIn[3] drops; next grant follows on the edge after the drop.
